// File: rtl/sdram_ctrl.sv
// Closed-page SDRAM controller: each 32-bit request is served as ACTIVE, two
// 16-bit column commands and PRECHARGE, followed by a one-cycle response.
module sdram_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned T_RCD       = 1,
  parameter int unsigned CAS_LAT     = 2,
  parameter int unsigned T_RP        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [25:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sdram_cke,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [13:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_i
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_RCD, S_WR0, S_WR1,
    S_RD0, S_RD1, S_CASW, S_PRE, S_RP, S_RESP
  } state_t;

  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] INIT_N = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] RCD_N  = CW'(T_RCD);
  localparam logic [CW-1:0] CAS_N  = CW'(CAS_LAT);
  localparam logic [CW-1:0] CAS_N1 = CW'(CAS_LAT + 1);
  localparam logic [CW-1:0] RP_N   = CW'(T_RP);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cmd;
  logic          lat_write;
  logic [1:0]    lat_bank;
  logic [8:0]    lat_col;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wstrb;
  logic [31:0]   cap;

  logic col_go;
  logic pre_go;
  logic rp_go;
  logic addr_lsb_unused;

  assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd;
  assign addr_lsb_unused = ^req_addr[1:0];

  // Zero-length waits are folded in by letting these strobes fire from the
  // preceding state; the blocks after the case override its default step.
  assign col_go = (state == S_ACT && RCD_N == '0) || (state == S_RCD && cnt == RCD_N);
  assign pre_go = (state == S_WR1) ||
                  ((state == S_RD1 || state == S_CASW) && cnt == CAS_N1);
  assign rp_go  = (state == S_PRE && RP_N == '0) || (state == S_RP && cnt == RP_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      cmd         <= CMD_DESEL;
      sdram_cke   <= 1'b0;
      sdram_a     <= '0;
      sdram_ba    <= '0;
      sdram_dqm   <= '1;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      lat_write   <= 1'b0;
      lat_bank    <= '0;
      lat_col     <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
      cap         <= '0;
    end else begin
      cmd         <= CMD_NOP;
      sdram_dq_oe <= 1'b0;
      resp_valid  <= 1'b0;

      case (state)
        S_INIT: begin
          sdram_cke <= 1'b1;
          if (cnt == INIT_N) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lat_write <= req_write;
            lat_bank  <= req_addr[25:24];
            lat_col   <= {req_addr[9:2], 1'b0};
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            req_ready <= 1'b0;
            cmd       <= CMD_ACT;
            sdram_ba  <= req_addr[25:24];
            sdram_a   <= req_addr[23:10];
            state     <= S_ACT;
          end
        end
        S_ACT: begin
          state <= S_RCD;
          cnt   <= CW'(1);
        end
        S_RCD: cnt <= cnt + CW'(1);
        S_WR0: begin
          cmd         <= CMD_WR;
          sdram_a     <= {5'b0, lat_col[8:1], 1'b1};
          sdram_dq_o  <= lat_wdata[31:16];
          sdram_dqm   <= ~lat_wstrb[3:2];
          sdram_dq_oe <= 1'b1;
          state       <= S_WR1;
        end
        S_RD0: begin
          cmd     <= CMD_RD;
          sdram_a <= {5'b0, lat_col[8:1], 1'b1};
          state   <= S_RD1;
          cnt     <= CW'(1);
        end
        S_RD1, S_CASW: begin
          // cnt counts cycles since RD0; data arrives CAS_LAT cycles after each READ
          if (cnt == CAS_N) cap[15:0] <= sdram_dq_i;
          if (cnt == CAS_N1) cap[31:16] <= sdram_dq_i;
          state <= S_CASW;
          cnt   <= cnt + CW'(1);
        end
        S_PRE: begin
          state <= S_RP;
          cnt   <= CW'(1);
        end
        S_RP: cnt <= cnt + CW'(1);
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase

      if (col_go) begin
        cmd     <= lat_write ? CMD_WR : CMD_RD;
        sdram_a <= {5'b0, lat_col};
        if (lat_write) begin
          sdram_dq_o  <= lat_wdata[15:0];
          sdram_dqm   <= ~lat_wstrb[1:0];
          sdram_dq_oe <= 1'b1;
          state       <= S_WR0;
        end else begin
          sdram_dqm <= 2'b00;
          state     <= S_RD0;
        end
      end

      if (pre_go) begin
        cmd       <= CMD_PRE;
        sdram_a   <= '0;
        sdram_ba  <= lat_bank;
        sdram_dqm <= 2'b11;
        state     <= S_PRE;
      end

      if (rp_go) begin
        resp_valid <= 1'b1;
        if (!lat_write) resp_rdata <= cap;
        state <= S_RESP;
      end
    end
  end

endmodule
